// File: rtl/bringup_pin_driver.sv
// bringup_pin_driver: drives a bank of pins with slow square waves for
// board bring-up continuity checks. Modes: OFF (released), ALL (every pin
// toggles), WALK (one pin at a time toggles, others low), HOLD (static high).
module bringup_pin_driver #(
    parameter int NUM_PINS          = 8,
    parameter int CLOCKS_PER_TOGGLE = 6000,
    parameter int DWELL_TICKS       = 64,
    localparam int AW = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          mode_i,
    output logic [NUM_PINS-1:0] pins_o,
    output logic [NUM_PINS-1:0] pins_oe_o,
    output logic [AW-1:0]       active_pin_o,
    output logic                walk_done_o,
    output logic                tick_o
);

    localparam int PW = $clog2(CLOCKS_PER_TOGGLE);
    localparam int DW = $clog2(DWELL_TICKS);

    localparam logic [PW-1:0] PRESC_LOAD = PW'(CLOCKS_PER_TOGGLE - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
    localparam logic [AW-1:0] ACT_LAST   = AW'(NUM_PINS - 1);

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_ALL  = 2'd1,
        MODE_WALK = 2'd2,
        MODE_HOLD = 2'd3
    } mode_e;

    // State registers
    mode_e               r_mode;
    logic [PW-1:0]       r_presc;
    logic                r_phase;
    logic [DW-1:0]       r_dwell;
    logic [AW-1:0]       r_active;

    // Output registers
    logic [NUM_PINS-1:0] r_pins;
    logic [NUM_PINS-1:0] r_pins_oe;
    logic [AW-1:0]       r_active_out;
    logic                r_walk_done;
    logic                r_tick;

    // Combinational next values
    logic                w_tick;
    logic                w_change;
    logic [PW-1:0]       w_presc_next;
    logic                w_phase_next;
    logic [DW-1:0]       w_dwell_next;
    logic [AW-1:0]       w_active_next;
    logic                w_done_next;
    logic [NUM_PINS-1:0] w_walk_pins;
    logic [NUM_PINS-1:0] w_pins_next;
    logic [NUM_PINS-1:0] w_oe_next;
    logic [AW-1:0]       w_active_out_next;

    assign w_tick   = (r_presc == '0);
    assign w_change = (mode_e'(mode_i) != r_mode);

    // Next-state: prescaler, phase, dwell and walking pin; a mode change
    // restarts everything and overrides any tick landing on the same edge.
    always_comb begin
        w_presc_next  = (w_change || w_tick) ? PRESC_LOAD : (r_presc - PW'(1));
        w_phase_next  = r_phase;
        w_dwell_next  = r_dwell;
        w_active_next = r_active;
        w_done_next   = 1'b0;
        if (w_change) begin
            w_phase_next  = 1'b0;
            w_dwell_next  = '0;
            w_active_next = '0;
        end else begin
            case (r_mode)
                MODE_ALL: begin
                    if (w_tick) begin
                        w_phase_next = ~r_phase;
                    end
                end
                MODE_WALK: begin
                    if (w_tick) begin
                        if (r_dwell == DWELL_LAST) begin
                            // Pin leaves low; hand over to the next pin.
                            w_dwell_next = '0;
                            w_phase_next = 1'b0;
                            if (r_active == ACT_LAST) begin
                                w_active_next = '0;
                                w_done_next   = 1'b1;
                            end else begin
                                w_active_next = r_active + AW'(1);
                            end
                        end else begin
                            w_dwell_next = r_dwell + DW'(1);
                            w_phase_next = ~r_phase;
                        end
                    end
                end
                default: begin
                    // OFF and HOLD never produce pin edges.
                    w_phase_next  = 1'b0;
                    w_dwell_next  = '0;
                    w_active_next = '0;
                end
            endcase
        end
    end

    // One-hot walking pattern: only the active pin carries the phase.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PINS; gi++) begin : g_walk
            assign w_walk_pins[gi] = w_phase_next && (w_active_next == AW'(gi));
        end
    endgenerate

    // Output pattern for the registered mode, using the phase/pin that this
    // edge produces so a tick and its pin edge appear together.
    always_comb begin
        w_pins_next       = '0;
        w_oe_next         = '0;
        w_active_out_next = '0;
        case (r_mode)
            MODE_ALL: begin
                w_oe_next   = '1;
                w_pins_next = {NUM_PINS{w_phase_next}};
            end
            MODE_WALK: begin
                w_oe_next         = '1;
                w_pins_next       = w_walk_pins;
                w_active_out_next = w_active_next;
            end
            MODE_HOLD: begin
                w_oe_next   = '1;
                w_pins_next = '1;
            end
            default: begin
                w_oe_next   = '0;
                w_pins_next = '0;
            end
        endcase
    end

    // State register with asynchronous reset to OFF.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mode   <= MODE_OFF;
            r_presc  <= PRESC_LOAD;
            r_phase  <= 1'b0;
            r_dwell  <= '0;
            r_active <= '0;
        end else begin
            r_mode   <= mode_e'(mode_i);
            r_presc  <= w_presc_next;
            r_phase  <= w_phase_next;
            r_dwell  <= w_dwell_next;
            r_active <= w_active_next;
        end
    end

    // Output registers; all outputs drop to 0 as soon as reset asserts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pins       <= '0;
            r_pins_oe    <= '0;
            r_active_out <= '0;
            r_walk_done  <= 1'b0;
            r_tick       <= 1'b0;
        end else begin
            r_pins       <= w_pins_next;
            r_pins_oe    <= w_oe_next;
            r_active_out <= w_active_out_next;
            r_walk_done  <= w_done_next;
            r_tick       <= w_tick;
        end
    end

    assign pins_o       = r_pins;
    assign pins_oe_o    = r_pins_oe;
    assign active_pin_o = r_active_out;
    assign walk_done_o  = r_walk_done;
    assign tick_o       = r_tick;

endmodule
